// File: rtl/memory_game_pkg.sv
// rtl/memory_game_pkg.sv - shared types and widths for the memory game datapath
package memory_game_pkg;

    localparam int PATTERN_W = 32;
    localparam int SCORE_W   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } playback_state_t;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pattern_playback_ctrl_if.sv
// rtl/pattern_playback_ctrl_if.sv - control and display signals of the playback sequencer
interface pattern_playback_ctrl_if #(
    parameter int PAT_W = memory_game_pkg::PATTERN_W,
    parameter int CNT_W = memory_game_pkg::SCORE_W
) ();

    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] length;
    logic             busy;
    logic             led_valid;
    logic             led_bit;
    logic [CNT_W-1:0] bit_idx;
    logic             done;

    modport master (
        output start, abort, pattern, length,
        input  busy, led_valid, led_bit, bit_idx, done
    );

    modport slave (
        input  start, abort, pattern, length,
        output busy, led_valid, led_bit, bit_idx, done
    );

endinterface

// File: rtl/pattern_playback_ctrl_phase_timer.sv
// rtl/pattern_playback_ctrl_phase_timer.sv - loadable down-counter timing the SHOW and GAP phases
module phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         clr,
    output logic         expired
);

    logic [W-1:0] r_cnt;

    // Count down to zero and hold there; a load restarts the phase, clr wins over load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    // Expiry looks only at the held count so the FSM may reload in the same cycle it sees it.
    assign expired = (r_cnt == '0);

endmodule

// File: rtl/pattern_playback_ctrl.sv
// rtl/pattern_playback_ctrl.sv - plays the stored pattern oldest-first as timed LED pulses
module pattern_playback_ctrl
    import memory_game_pkg::*;
#(
    parameter int PAT_W      = PATTERN_W,
    parameter int CNT_W      = SCORE_W,
    parameter int ON_CYCLES  = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    pattern_playback_ctrl_if.slave  pb
);

    localparam int TMR_W = $clog2(imax(ON_CYCLES, GAP_CYCLES) + 1);
    localparam int IDX_W = $clog2(PAT_W);
    localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PAT_LEN  = CNT_W'(PAT_W);

    playback_state_t  r_state;
    playback_state_t  w_next;
    logic [PAT_W-1:0] r_pat;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_bit_idx;
    logic [CNT_W-1:0] w_eff_len;
    logic [IDX_W-1:0] w_sel;
    logic             w_last;
    logic             w_capture;
    logic             w_clr_idx;
    logic             w_inc_idx;
    logic             w_tmr_load;
    logic             w_tmr_clr;
    logic [TMR_W-1:0] w_tmr_val;
    logic             w_expired;

    assign w_eff_len = (pb.length > PAT_LEN) ? PAT_LEN : pb.length;
    assign w_last    = (r_bit_idx == r_len - CNT_W'(1));
    assign w_sel     = IDX_W'(r_len - CNT_W'(1) - r_bit_idx);

    phase_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .clr      (w_tmr_clr),
        .expired  (w_expired)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and datapath controls; abort from any active state overrides everything.
    always_comb begin
        w_next     = r_state;
        w_capture  = 1'b0;
        w_clr_idx  = 1'b0;
        w_inc_idx  = 1'b0;
        w_tmr_load = 1'b0;
        w_tmr_clr  = 1'b0;
        w_tmr_val  = ON_LOAD;
        case (r_state)
            IDLE: begin
                if (pb.start && !pb.abort) begin
                    w_capture = 1'b1;
                    w_clr_idx = 1'b1;
                    if (w_eff_len == '0) begin
                        w_next = DONE;
                    end else begin
                        w_next     = SHOW;
                        w_tmr_load = 1'b1;
                    end
                end
            end
            SHOW: begin
                if (w_expired) begin
                    w_next     = GAP;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = GAP_LOAD;
                end
            end
            GAP: begin
                if (w_expired) begin
                    if (w_last) begin
                        w_next = DONE;
                    end else begin
                        w_next     = SHOW;
                        w_inc_idx  = 1'b1;
                        w_tmr_load = 1'b1;
                    end
                end
            end
            DONE: begin
                w_next    = IDLE;
                w_clr_idx = 1'b1;
            end
            default: w_next = IDLE;
        endcase
        if (pb.abort && r_state != IDLE) begin
            w_next     = IDLE;
            w_clr_idx  = 1'b1;
            w_inc_idx  = 1'b0;
            w_tmr_load = 1'b0;
            w_tmr_clr  = 1'b1;
        end
    end

    // Capture pattern and clamped length at start; step the playback position between bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat     <= '0;
            r_len     <= '0;
            r_bit_idx <= '0;
        end else begin
            if (w_capture) begin
                r_pat <= pb.pattern;
                r_len <= w_eff_len;
            end
            if (w_clr_idx) begin
                r_bit_idx <= '0;
            end else if (w_inc_idx) begin
                r_bit_idx <= r_bit_idx + CNT_W'(1);
            end
        end
    end

    assign pb.busy      = (r_state != IDLE);
    assign pb.led_valid = (r_state == SHOW);
    assign pb.led_bit   = (r_state == SHOW) ? r_pat[w_sel] : 1'b0;
    assign pb.bit_idx   = r_bit_idx;
    assign pb.done      = (r_state == DONE);

endmodule

// File: tb/tb_pattern_playback_ctrl.sv
// tb/tb_pattern_playback_ctrl.sv - scoreboard bench for pattern_playback_ctrl
module tb_pattern_playback_ctrl;

    localparam int ON  = 2;
    localparam int GAP = 1;
    localparam int PER = ON + GAP;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pattern_playback_ctrl_if pb ();

    pattern_playback_ctrl #(
        .PAT_W      (32),
        .CNT_W      (16),
        .ON_CYCLES  (ON),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .pb  (pb)
    );

    typedef struct {
        int   c;
        logic b;
        int   idx;
    } led_exp_t;

    led_exp_t q_led[$];
    int       q_done[$];
    int       checks = 0;
    int       errors = 0;
    int       cyc    = 0;
    bit       mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_play(input logic [31:0] pat, input int len, input int k,
                               input int cutoff, input bit exp_done);
        int eff;
        int c;
        led_exp_t e;
        eff = (len > 32) ? 32 : len;
        for (int i = 0; i < eff; i++) begin
            for (int j = 0; j < ON; j++) begin
                c = k + 1 + i * PER + j;
                if (c < cutoff) begin
                    e.c   = c;
                    e.b   = pat[eff-1-i];
                    e.idx = i;
                    q_led.push_back(e);
                end
            end
        end
        if (exp_done) q_done.push_back(k + 1 + eff * PER);
    endtask

    // Start is held for one cycle k; returns at the negedge of cycle k+1.
    task automatic start_play(input logic [31:0] pat, input int len, input int cutoff_rel,
                              input bit exp_done);
        int k;
        @(negedge clk);
        pb.pattern = pat;
        pb.length  = 16'(len);
        pb.start   = 1'b1;
        k = cyc;
        expect_play(pat, len, k, k + cutoff_rel, exp_done);
        @(negedge clk);
        pb.start = 1'b0;
    endtask

    // Monitor: pop the scoreboard whenever the DUT shows a bit or pulses done.
    always @(negedge clk) begin
        led_exp_t e;
        int dc;
        if (mon_en) begin
            if (pb.led_valid) begin
                if (q_led.size() == 0) begin
                    chk("led_unexpected", 1, 0);
                end else begin
                    e = q_led.pop_front();
                    chk("led_cycle", cyc, e.c);
                    chk("led_bit", pb.led_bit, e.b);
                    chk("bit_idx", pb.bit_idx, e.idx);
                end
            end else begin
                chk("led_bit_blank", pb.led_bit, 0);
            end
            if (pb.done) begin
                if (q_done.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    dc = q_done.pop_front();
                    chk("done_cycle", cyc, dc);
                end
            end
        end
    end

    initial begin
        pb.start   = 1'b0;
        pb.abort   = 1'b0;
        pb.pattern = '0;
        pb.length  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", pb.busy, 0);
        chk("rst_led_valid", pb.led_valid, 0);
        chk("rst_led_bit", pb.led_bit, 0);
        chk("rst_done", pb.done, 0);
        chk("rst_bit_idx", pb.bit_idx, 0);
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // 0b101, length 3: pulses in k+1..2, k+4..5, k+7..8, done at k+10
        start_play(32'b101, 3, 100000, 1'b1);
        chk("busy_running", pb.busy, 1);
        repeat (9) @(negedge clk);
        chk("done_k10", pb.done, 1);
        @(negedge clk);
        chk("busy_after_done", pb.busy, 0);

        // length 0: straight to DONE for one cycle
        start_play(32'hFFFF, 0, 100000, 1'b1);
        chk("busy_len0", pb.busy, 1);
        chk("led_valid_len0", pb.led_valid, 0);
        @(negedge clk);
        chk("busy_len0_end", pb.busy, 0);

        // length 40 clamps to 32 bits
        start_play(32'hFFFF_FFFF, 40, 100000, 1'b1);
        repeat (96) @(negedge clk);
        chk("done_len40", pb.done, 1);
        @(negedge clk);
        chk("busy_after_len40", pb.busy, 0);

        // pattern, length and start changed mid-run have no effect
        start_play(32'b0110, 4, 100000, 1'b1);
        repeat (4) @(negedge clk);
        pb.pattern = 32'h9;
        pb.length  = 16'd2;
        pb.start   = 1'b1;
        @(negedge clk);
        pb.start = 1'b0;
        repeat (7) @(negedge clk);
        chk("done_midrun", pb.done, 1);
        @(negedge clk);
        chk("busy_after_midrun", pb.busy, 0);

        // abort during the second SHOW
        start_play(32'b1010, 4, 5, 1'b0);
        repeat (3) @(negedge clk);
        chk("show2_before_abort", pb.led_valid, 1);
        pb.abort = 1'b1;
        @(negedge clk);
        pb.abort = 1'b0;
        chk("abort_busy", pb.busy, 0);
        chk("abort_led_valid", pb.led_valid, 0);
        chk("abort_done", pb.done, 0);
        chk("abort_bit_idx", pb.bit_idx, 0);
        repeat (3) @(negedge clk);
        start_play(32'b1, 1, 100000, 1'b1);
        repeat (3) @(negedge clk);
        @(negedge clk);
        chk("busy_after_restart", pb.busy, 0);

        // asynchronous reset in the second GAP
        start_play(32'b10, 2, 6, 1'b0);
        repeat (5) @(negedge clk);
        chk("gap2_bit_idx", pb.bit_idx, 1);
        chk("gap2_busy", pb.busy, 1);
        rst = 1'b1;
        #1;
        chk("arst_busy", pb.busy, 0);
        chk("arst_bit_idx", pb.bit_idx, 0);
        chk("arst_led_valid", pb.led_valid, 0);
        chk("arst_done", pb.done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_after_rst", pb.busy, 0);

        repeat (2) @(negedge clk);
        chk("led_queue_drained", q_led.size(), 0);
        chk("done_queue_drained", q_done.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
